// File: rtl/matmul_job_sequencer.sv
// Matrix-multiply job sequencer: streams A and B from system memory into the
// accelerator, starts it, polls for completion, then copies C back to memory.
module matmul_job_sequencer #(
    parameter int DIM_MAX      = 3,
    parameter int POLL_TIMEOUT = 4095
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_job_valid,
    output logic        o_job_ready,
    input  logic [7:0]  i_rows,
    input  logic [7:0]  i_inner,
    input  logic [7:0]  i_cols,
    input  logic [31:0] i_a_base,
    input  logic [31:0] i_b_base,
    input  logic [31:0] i_c_base,
    output logic        o_mem_cyc,
    output logic        o_mem_we,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdt,
    output logic [10:0] o_acc_address,
    output logic [31:0] o_acc_data,
    output logic        o_acc_we,
    input  logic [31:0] i_acc_rdt,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    localparam logic [7:0] DIM_LIM = 8'(DIM_MAX);
    localparam int         PW      = $clog2(POLL_TIMEOUT + 1) + 1;
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_TIMEOUT);

    typedef enum logic [3:0] {
        IDLE, CHECK, A_RD, A_WR, B_RD, B_WR, GO_SET, GO_CLR, POLL, C_RD, C_WR, DONE
    } state_t;

    state_t        state, state_n;
    logic [7:0]    rows_q, inner_q, cols_q, rows_n, inner_n, cols_n;
    logic [31:0]   a_base_q, b_base_q, c_base_q, a_base_n, b_base_n, c_base_n;
    logic [7:0]    idx_q, idx_n;
    logic [15:0]   count_q, count_n;
    logic [PW-1:0] poll_q, poll_n;
    logic          mem_cyc_n, mem_we_n, acc_we_n, done_n, err_n;
    logic [31:0]   mem_adr_n, mem_dat_n, acc_data_n;
    logic [10:0]   acc_addr_n;
    logic          last_elem, bad_dims;

    assign o_job_ready = (state == IDLE);
    assign o_busy      = (state != IDLE);
    assign last_elem   = ({8'd0, idx_q} == (count_q - 16'd1));
    assign bad_dims    = (rows_q == 8'd0) || (rows_q > DIM_LIM) ||
                         (inner_q == 8'd0) || (inner_q > DIM_LIM) ||
                         (cols_q == 8'd0) || (cols_q > DIM_LIM);

    // State and datapath registers; everything clears asynchronously on reset
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            rows_q        <= '0;
            inner_q       <= '0;
            cols_q        <= '0;
            a_base_q      <= '0;
            b_base_q      <= '0;
            c_base_q      <= '0;
            idx_q         <= '0;
            count_q       <= '0;
            poll_q        <= '0;
            o_mem_cyc     <= 1'b0;
            o_mem_we      <= 1'b0;
            o_mem_adr     <= '0;
            o_mem_dat     <= '0;
            o_acc_address <= '0;
            o_acc_data    <= '0;
            o_acc_we      <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            state         <= state_n;
            rows_q        <= rows_n;
            inner_q       <= inner_n;
            cols_q        <= cols_n;
            a_base_q      <= a_base_n;
            b_base_q      <= b_base_n;
            c_base_q      <= c_base_n;
            idx_q         <= idx_n;
            count_q       <= count_n;
            poll_q        <= poll_n;
            o_mem_cyc     <= mem_cyc_n;
            o_mem_we      <= mem_we_n;
            o_mem_adr     <= mem_adr_n;
            o_mem_dat     <= mem_dat_n;
            o_acc_address <= acc_addr_n;
            o_acc_data    <= acc_data_n;
            o_acc_we      <= acc_we_n;
            o_done        <= done_n;
            o_err         <= err_n;
        end
    end

    // Next-state and next-output decode; pulses default low, everything else holds
    always_comb begin
        state_n    = state;
        rows_n     = rows_q;
        inner_n    = inner_q;
        cols_n     = cols_q;
        a_base_n   = a_base_q;
        b_base_n   = b_base_q;
        c_base_n   = c_base_q;
        idx_n      = idx_q;
        count_n    = count_q;
        poll_n     = poll_q;
        mem_cyc_n  = o_mem_cyc;
        mem_we_n   = o_mem_we;
        mem_adr_n  = o_mem_adr;
        mem_dat_n  = o_mem_dat;
        acc_addr_n = o_acc_address;
        acc_data_n = o_acc_data;
        acc_we_n   = 1'b0;
        done_n     = 1'b0;
        err_n      = 1'b0;
        case (state)
            IDLE: begin
                if (i_job_valid) begin
                    rows_n   = i_rows;
                    inner_n  = i_inner;
                    cols_n   = i_cols;
                    a_base_n = i_a_base;
                    b_base_n = i_b_base;
                    c_base_n = i_c_base;
                    state_n  = CHECK;
                end
            end
            CHECK: begin
                if (bad_dims) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    idx_n     = '0;
                    count_n   = 16'(rows_q) * 16'(inner_q);
                    mem_cyc_n = 1'b1;
                    mem_we_n  = 1'b0;
                    mem_adr_n = a_base_q;
                    state_n   = A_RD;
                end
            end
            A_RD, B_RD: begin
                if (o_mem_cyc && i_mem_ack) begin
                    mem_cyc_n  = 1'b0;
                    acc_we_n   = 1'b1;
                    acc_addr_n = {(state == A_RD) ? 3'd1 : 3'd2, idx_q};
                    acc_data_n = i_mem_rdt;
                    state_n    = (state == A_RD) ? A_WR : B_WR;
                end
            end
            A_WR: begin
                mem_cyc_n = 1'b1;
                if (last_elem) begin
                    idx_n     = '0;
                    count_n   = 16'(inner_q) * 16'(cols_q);
                    mem_adr_n = b_base_q;
                    state_n   = B_RD;
                end else begin
                    idx_n     = idx_q + 8'd1;
                    mem_adr_n = a_base_q + {22'd0, idx_q + 8'd1, 2'b00};
                    state_n   = A_RD;
                end
            end
            B_WR: begin
                if (last_elem) begin
                    acc_we_n   = 1'b1;
                    acc_addr_n = '0;
                    acc_data_n = {7'b0, 1'b1, cols_q, inner_q, rows_q};
                    state_n    = GO_SET;
                end else begin
                    mem_cyc_n = 1'b1;
                    idx_n     = idx_q + 8'd1;
                    mem_adr_n = b_base_q + {22'd0, idx_q + 8'd1, 2'b00};
                    state_n   = B_RD;
                end
            end
            GO_SET: begin
                acc_we_n       = 1'b1;
                acc_data_n[24] = 1'b0;
                state_n        = GO_CLR;
            end
            GO_CLR: begin
                acc_addr_n = {3'd4, 8'd0};
                poll_n     = '0;
                state_n    = POLL;
            end
            POLL: begin
                // The first POLL cycle only presents the address; the registered
                // status is compared from the second cycle onward.
                if ((poll_q != '0) && (i_acc_rdt == 32'd1)) begin
                    idx_n      = '0;
                    count_n    = 16'(rows_q) * 16'(cols_q);
                    acc_addr_n = {3'd3, 8'd0};
                    state_n    = C_RD;
                end else if (poll_q == POLL_LAST) begin
                    err_n      = 1'b1;
                    acc_addr_n = '0;
                    state_n    = IDLE;
                end else begin
                    poll_n = poll_q + 1'b1;
                end
            end
            C_RD: begin
                state_n = C_WR;
            end
            C_WR: begin
                if (!o_mem_cyc) begin
                    mem_cyc_n = 1'b1;
                    mem_we_n  = 1'b1;
                    mem_adr_n = c_base_q + {22'd0, idx_q, 2'b00};
                    mem_dat_n = i_acc_rdt;
                end else if (i_mem_ack) begin
                    mem_cyc_n = 1'b0;
                    mem_we_n  = 1'b0;
                    if (last_elem) begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end else begin
                        idx_n      = idx_q + 8'd1;
                        acc_addr_n = {3'd3, idx_q + 8'd1};
                        state_n    = C_RD;
                    end
                end
            end
            DONE: begin
                acc_addr_n = '0;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_matmul_job_sequencer.sv
// Scoreboard bench for matmul_job_sequencer with behavioural memory and accelerator.
module tb_matmul_job_sequencer;

    localparam int DIM = 5;
    localparam int T   = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [7:0]  job_rows = '0, job_inner = '0, job_cols = '0;
    logic [31:0] a_base = '0, b_base = '0, c_base = '0;
    logic        mem_cyc, mem_we, mem_ack;
    logic [31:0] mem_adr, mem_dat, mem_rdt;
    logic [10:0] acc_address;
    logic [31:0] acc_data, acc_rdt;
    logic        acc_we, busy, done, err;

    matmul_job_sequencer #(.DIM_MAX(DIM), .POLL_TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst(rst), .i_job_valid(job_valid), .o_job_ready(job_ready),
        .i_rows(job_rows), .i_inner(job_inner), .i_cols(job_cols),
        .i_a_base(a_base), .i_b_base(b_base), .i_c_base(c_base),
        .o_mem_cyc(mem_cyc), .o_mem_we(mem_we), .o_mem_adr(mem_adr), .o_mem_dat(mem_dat),
        .i_mem_ack(mem_ack), .i_mem_rdt(mem_rdt),
        .o_acc_address(acc_address), .o_acc_data(acc_data), .o_acc_we(acc_we),
        .i_acc_rdt(acc_rdt), .o_busy(busy), .o_done(done), .o_err(err)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_MEM_RD, EV_MEM_WR, EV_ACC_WR, EV_DONE, EV_ERR} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc_cnt = 0;
    int   mark = 0;
    bit   rand_delay = 1'b0;
    bit   hang = 1'b0;
    logic [31:0] mem [0:1023];

    int c333[9] = '{15, 18, 21, 42, 54, 66, 69, 90, 111};
    int c252[9] = '{95, 110, 220, 260, 0, 0, 0, 0, 0};

    // Free-running cycle counter used to time error pulses
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Accelerator model: A/B/C banks, control register, registered readback
    logic [31:0] amem [0:255];
    logic [31:0] bmem [0:255];
    logic [31:0] cmem [0:255];
    logic        status;
    int          cdown;

    function automatic logic [31:0] dot(int i, int j, int n, int c);
        logic [31:0] s = '0;
        for (int k = 0; k < n; k++) s = s + amem[i*n+k] * bmem[k*c+j];
        return s;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            acc_rdt <= '0;
            status  <= 1'b0;
            cdown   <= 0;
        end else begin
            acc_rdt <= (acc_address[10:8] == 3'd4) ? {31'b0, status} :
                       (acc_address[10:8] == 3'd3) ? cmem[acc_address[7:0]] : '0;
            if (acc_we && acc_address[10:8] == 3'd1) amem[acc_address[7:0]] <= acc_data;
            if (acc_we && acc_address[10:8] == 3'd2) bmem[acc_address[7:0]] <= acc_data;
            if (acc_we && acc_address == 11'd0 && acc_data[24]) begin
                for (int i = 0; i < int'(acc_data[7:0]); i++)
                    for (int j = 0; j < int'(acc_data[23:16]); j++)
                        cmem[i*int'(acc_data[23:16])+j] <=
                            dot(i, j, int'(acc_data[15:8]), int'(acc_data[23:16]));
                status <= 1'b0;
                cdown  <= 6;
            end else if (cdown > 0) begin
                cdown <= cdown - 1;
                if (cdown == 1 && !hang) status <= 1'b1;
            end
        end
    end

    // Memory responder: ack after 0 (or 0-7 random) cycles of o_mem_cyc
    initial begin
        int wait_cnt;
        wait_cnt = -1;
        mem_ack  = 1'b0;
        mem_rdt  = '0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 9; i++) begin
            mem[64+i]  = 32'(i);
            mem[128+i] = 32'(i);
        end
        for (int i = 0; i < 10; i++) begin
            mem[256+i] = 32'(i + 1);
            mem[320+i] = 32'(i + 1);
        end
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (rst) begin
                wait_cnt = -1;
            end else if (mem_cyc) begin
                if (wait_cnt < 0) wait_cnt = rand_delay ? int'($urandom_range(0, 7)) : 0;
                if (wait_cnt == 0) begin
                    mem_ack = 1'b1;
                    if (!mem_we) mem_rdt = mem[mem_adr[11:2]];
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic push(kind_t k, logic [31:0] a, logic [31:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic got(kind_t k, logic [31:0] a, logic [31:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h, required no event", k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.addr !== a || e.data !== d) begin
                errors++;
                $display("FAIL event: got kind=%0d addr=%h data=%h, required kind=%0d addr=%h data=%h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: turns DUT activity into events and checks the memory handshake
    logic        p_ok = 1'b0, p_cyc, p_we, p_ack;
    logic [31:0] p_adr, p_dat;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                p_ok = 1'b0;
            end else begin
                if (p_ok && p_cyc && !p_ack) begin
                    checks++;
                    if ({mem_cyc, mem_we, mem_adr, mem_dat} !== {p_cyc, p_we, p_adr, p_dat}) begin
                        errors++;
                        $display("FAIL mem_stable: got cyc=%b we=%b adr=%h dat=%h, required cyc=%b we=%b adr=%h dat=%h",
                                 mem_cyc, mem_we, mem_adr, mem_dat, p_cyc, p_we, p_adr, p_dat);
                    end
                end
                if (p_ok && p_cyc && p_ack) check("mem_cyc_drop", {31'b0, mem_cyc}, 32'd0);
                check("ready_vs_busy", {31'b0, job_ready}, {31'b0, !busy});
                if (job_valid && job_ready) mark = cyc_cnt;
                if (mem_cyc && mem_ack) got(mem_we ? EV_MEM_WR : EV_MEM_RD, mem_adr, mem_we ? mem_dat : 32'd0);
                if (acc_we) begin
                    got(EV_ACC_WR, {21'b0, acc_address}, acc_data);
                    if (acc_address == 11'd0 && !acc_data[24]) mark = cyc_cnt;
                end
                if (done) got(EV_DONE, 32'd0, 32'd0);
                if (err) got(EV_ERR, 32'd0, 32'(cyc_cnt - mark));
                p_ok  = 1'b1;
                p_cyc = mem_cyc;
                p_we  = mem_we;
                p_ack = mem_ack;
                p_adr = mem_adr;
                p_dat = mem_dat;
            end
        end
    end

    // Expected event stream of a valid job; a hung accelerator ends in ERR
    // one POLL entry cycle plus T checked cycles after the clearing write.
    task automatic push_job(int r, int n, int c, logic [31:0] ab, logic [31:0] bb,
                            logic [31:0] cb, input int cexp[9], bit expect_hang);
        logic [31:0] ctrl;
        for (int i = 0; i < r*n; i++) begin
            push(EV_MEM_RD, ab + 32'(4*i), 32'd0);
            push(EV_ACC_WR, {21'b0, 3'd1, 8'(i)}, mem[int'(ab[11:2]) + i]);
        end
        for (int i = 0; i < n*c; i++) begin
            push(EV_MEM_RD, bb + 32'(4*i), 32'd0);
            push(EV_ACC_WR, {21'b0, 3'd2, 8'(i)}, mem[int'(bb[11:2]) + i]);
        end
        ctrl = {7'b0, 1'b1, 8'(c), 8'(n), 8'(r)};
        push(EV_ACC_WR, 32'd0, ctrl);
        push(EV_ACC_WR, 32'd0, ctrl & ~32'h0100_0000);
        if (expect_hang) begin
            push(EV_ERR, 32'd0, 32'(T + 2));
        end else begin
            for (int j = 0; j < r*c; j++) push(EV_MEM_WR, cb + 32'(4*j), 32'(cexp[j]));
            push(EV_DONE, 32'd0, 32'd0);
        end
    endtask

    task automatic issue(int r, int n, int c, logic [31:0] ab, logic [31:0] bb, logic [31:0] cb);
        @(posedge clk);
        #1;
        job_rows  = 8'(r);
        job_inner = 8'(n);
        job_cols  = 8'(c);
        a_base    = ab;
        b_base    = bb;
        c_base    = cb;
        job_valid = 1'b1;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_idle(string name, int maxc);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL %s_timeout: got %0d events pending after %0d cycles, required 0", name, exp_q.size(), n);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_ctl"}, {26'b0, mem_cyc, mem_we, acc_we, busy, done, err}, 32'd0);
        check({tag, "_mem_adr"}, mem_adr, 32'd0);
        check({tag, "_mem_dat"}, mem_dat, 32'd0);
        check({tag, "_acc_addr"}, {21'b0, acc_address}, 32'd0);
        check({tag, "_acc_data"}, acc_data, 32'd0);
        check({tag, "_ready"}, {31'b0, job_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 3x3x3, A = B = 0..8, no memory wait states
        push_job(3, 3, 3, 32'h100, 32'h200, 32'h300, c333, 1'b0);
        issue(3, 3, 3, 32'h100, 32'h200, 32'h300);
        wait_idle("job333", 2000);

        // 2x5x2 with a job offered while busy, which must be ignored
        push_job(2, 5, 2, 32'h400, 32'h500, 32'h600, c252, 1'b0);
        issue(2, 5, 2, 32'h400, 32'h500, 32'h600);
        repeat (20) @(posedge clk);
        #1;
        job_rows  = 8'd0;
        job_valid = 1'b1;
        @(posedge clk);
        #1;
        job_valid = 1'b0;
        wait_idle("job252", 2000);

        // Illegal dimensions: error pulse two cycles after acceptance, no traffic
        push(EV_ERR, 32'd0, 32'd2);
        issue(2, 0, 2, 32'h100, 32'h200, 32'h300);
        wait_idle("inner0", 50);
        push(EV_ERR, 32'd0, 32'd2);
        issue(DIM + 1, 1, 1, 32'h100, 32'h200, 32'h300);
        wait_idle("rows_big", 50);

        // Accelerator never reports completion
        hang = 1'b1;
        push_job(1, 1, 1, 32'h100, 32'h200, 32'h300, c333, 1'b1);
        issue(1, 1, 1, 32'h100, 32'h200, 32'h300);
        wait_idle("poll_timeout", 500);
        check("timeout_ready", {31'b0, job_ready}, 32'd1);
        check("timeout_busy", {31'b0, busy}, 32'd0);
        hang = 1'b0;

        // Random memory wait states
        rand_delay = 1'b1;
        push_job(3, 3, 3, 32'h100, 32'h200, 32'h700, c333, 1'b0);
        issue(3, 3, 3, 32'h100, 32'h200, 32'h700);
        wait_idle("job333_rand", 4000);

        // Reset while B is being loaded, then a clean job
        push_job(3, 3, 3, 32'h100, 32'h200, 32'h700, c333, 1'b0);
        issue(3, 3, 3, 32'h100, 32'h200, 32'h700);
        n = 0;
        while (!(acc_we && acc_address == {3'd2, 8'd4}) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("reach_b_wr", {31'b0, n < 1000}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("midjob_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push_job(3, 3, 3, 32'h100, 32'h200, 32'h300, c333, 1'b0);
        issue(3, 3, 3, 32'h100, 32'h200, 32'h300);
        wait_idle("after_reset", 4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matmul_job_sequencer.md
MATMUL_JOB_SEQUENCER -- requirements
Module: matmul_job_sequencer

Interface
REQ-001 Parameter DIM_MAX, default 3: maximum value of each matrix dimension; DIM_MAX*DIM_MAX SHALL be <= 256.
REQ-002 Parameter POLL_TIMEOUT, default 4095: maximum number of status-poll cycles before the job is aborted.
REQ-003 i_clk  in  1  the single clock; all state changes on the rising edge.
REQ-004 i_rst  in  1  asynchronous, active-high reset.
REQ-005 i_job_valid / o_job_ready  in/out  1  job handshake.
REQ-006 i_rows, i_inner, i_cols  in  8 each  dimensions: A is rows x inner, B is inner x cols, C is rows x cols.
REQ-007 i_a_base, i_b_base, i_c_base  in  32 each  system byte addresses; operands and results are row-major 32-bit words.
REQ-008 o_mem_cyc, o_mem_we, o_mem_adr[31:0], o_mem_dat[31:0]  out  system memory request.
REQ-009 i_mem_ack  in  1, i_mem_rdt  in  32  system memory completion and read data.
REQ-010 o_acc_address[10:0], o_acc_data[31:0], o_acc_we  out  accelerator bus; address = {region[2:0], index[7:0]}.
REQ-011 i_acc_rdt  in  32  accelerator read data, registered (valid one cycle after the address).
REQ-012 o_busy  out  1, o_done  out  1 (pulse), o_err  out  1 (pulse).

Function
REQ-013 o_job_ready SHALL be 1 only in IDLE; on i_job_valid && o_job_ready, all job fields SHALL be latched and the FSM SHALL enter CHECK.
REQ-014 CHECK: if any dimension is 0 or > DIM_MAX, pulse o_err for 1 cycle and return to IDLE with no memory or accelerator access.
REQ-015 States: IDLE, CHECK, A_RD, A_WR, B_RD, B_WR, GO_SET, GO_CLR, POLL, C_RD, C_WR, DONE.
REQ-016 A_RD/A_WR: for i = 0..rows*inner-1, read word i_a_base+4i from memory, then write it for 1 cycle with o_acc_we=1 to accelerator address {3'd1, i}.
REQ-017 B_RD/B_WR: same as REQ-016 with i_b_base, region 3'd2, and count inner*cols.
REQ-018 GO_SET: write control word {7'b0, 1'b1, cols, inner, rows} to {3'd0, 8'd0} for 1 cycle; GO_CLR: write the same word with bit 24 = 0 on the next cycle.
REQ-019 POLL: drive {3'd4, 8'd0}; on each cycle starting one cycle after entry, i_acc_rdt == 1 SHALL advance to C_RD; after POLL_TIMEOUT cycles without a match, pulse o_err and return to IDLE.
REQ-020 C_RD/C_WR: for j = 0..rows*cols-1, drive {3'd3, j}, capture i_acc_rdt one cycle later, then write it to memory at i_c_base+4j.
REQ-021 DONE: pulse o_done for 1 cycle, then return to IDLE.
REQ-022 Memory handshake: o_mem_cyc, o_mem_we, o_mem_adr, and o_mem_dat SHALL stay stable from assertion until the cycle i_mem_ack=1; o_mem_cyc SHALL drop in the following cycle; read data SHALL be captured on the ack cycle; a new request SHALL not start in the same cycle as the ack.
REQ-023 Element counters SHALL be 8 bits wide; counts SHALL be computed as 16-bit products; the last element is count-1, with no wrap.
REQ-024 o_acc_we SHALL be high for exactly one cycle per accelerator write; o_acc_address and o_acc_data SHALL be stable during that cycle.
REQ-025 o_busy SHALL be 1 in every state except IDLE.
REQ-026 i_job_valid while busy SHALL be ignored and SHALL not be latched.

Reset
REQ-027 While i_rst=1, asynchronously: FSM=IDLE, counters=0, o_job_ready=1, and every other output=0 (o_mem_cyc, o_mem_we, o_acc_we, o_busy, o_done, o_err, all buses).
REQ-028 Reset mid-job SHALL abandon the transfer immediately with no completion pulse; the first job after reset SHALL run normally.

Verification
REQ-029 3x3x3 job, A = B = 0..8 in memory, with Matrix_TOP attached -> C at i_c_base = 15,18,21,42,54,66,69,90,111; o_done pulses once.
REQ-030 2x5x2 job -> exactly 10 A writes (index 0..9), 10 B writes, then 2 control writes (bit 24 = 1, then 0), then 4 result stores.
REQ-031 i_inner=0, or i_rows=DIM_MAX+1 -> o_err pulses within 2 cycles; o_mem_cyc and o_acc_we never assert.
REQ-032 Accelerator model that never reports status 1 -> o_err pulses after POLL_TIMEOUT poll cycles; FSM returns to IDLE; o_job_ready=1.
REQ-033 Memory ack delays of 0-7 random cycles per transfer -> results identical to REQ-029 and request signals stable until ack (assertion-checked).
REQ-034 i_rst pulsed during B_WR -> all outputs 0 in the same cycle (o_job_ready=1); a subsequent job completes correctly.
